backtrack_unit: RTL and testbench

Reader-side consumer of the solver's implication/decision trail stack. On a conflict it pops the trail from the top and clears each popped variable's assignment in the variable-state memory. It stops at the most recent decision entry, flips that decision and pushes it back as an implied entry, or it reports UNSAT if the trail empties first. It sits between the conflict detector, the trail stack and the variable-state memory in the DPLL datapath.

---
 rtl/backtrack_unit.sv | 149 ++++++++++++++
 tb/tb_backtrack_unit.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/backtrack_unit.sv
// Trail-stack backtracker: pops implied entries on a conflict, unassigns each
// popped variable, flips the most recent decision or reports UNSAT.
module backtrack_unit #(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_W        = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_unsat,
    output logic [VAR_W-1:0] o_pop_count,
    input  logic             i_stack_empty,
    input  logic             i_stack_type,
    input  logic             i_stack_val,
    input  logic [VAR_W-1:0] i_stack_var,
    output logic             o_stack_pop,
    output logic             o_stack_push,
    output logic             o_push_type,
    output logic             o_push_val,
    output logic [VAR_W-1:0] o_push_var,
    output logic             o_var_wr_en,
    output logic [VAR_W-1:0] o_var_wr_addr,
    output logic [1:0]       o_var_wr_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNWIND = 2'd1,
        ST_FLIP   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_unsat;
    logic [VAR_W-1:0] r_pop_count;
    logic [VAR_W-1:0] r_var;
    logic             r_val;

    // Every variable index must be representable in VAR_W bits
    if (NUM_VARIABLE > (1 << VAR_W)) begin : g_param_check
        $error("NUM_VARIABLE does not fit in VAR_W bits");
    end

    // Backtrack sequencing and registered status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_unsat     <= 1'b0;
            r_pop_count <= {VAR_W{1'b0}};
            r_var       <= {VAR_W{1'b0}};
            r_val       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state     <= ST_UNWIND;
                        r_busy      <= 1'b1;
                        r_unsat     <= 1'b0;
                        r_pop_count <= {VAR_W{1'b0}};
                    end
                end
                ST_UNWIND: begin
                    if (i_stack_empty) begin
                        r_state <= ST_FINISH;
                        r_done  <= 1'b1;
                        r_unsat <= 1'b1;
                    end else begin
                        // Count saturates rather than wrapping on very deep trails
                        if (r_pop_count != {VAR_W{1'b1}}) begin
                            r_pop_count <= r_pop_count + {{(VAR_W-1){1'b0}}, 1'b1};
                        end
                        if (i_stack_type) begin
                            r_var   <= i_stack_var;
                            r_val   <= i_stack_val;
                            r_state <= ST_FLIP;
                        end
                    end
                end
                ST_FLIP: begin
                    r_state <= ST_FINISH;
                    r_done  <= 1'b1;
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stack and variable-memory strobes decoded from state and the live stack top
    always_comb begin
        o_stack_pop    = 1'b0;
        o_stack_push   = 1'b0;
        o_push_type    = 1'b0;
        o_push_val     = 1'b0;
        o_push_var     = {VAR_W{1'b0}};
        o_var_wr_en    = 1'b0;
        o_var_wr_addr  = {VAR_W{1'b0}};
        o_var_wr_state = 2'b00;
        case (r_state)
            ST_UNWIND: begin
                if (!i_stack_empty) begin
                    o_stack_pop    = 1'b1;
                    o_var_wr_en    = 1'b1;
                    o_var_wr_addr  = i_stack_var;
                    o_var_wr_state = 2'b00;
                end else begin
                    o_stack_pop    = 1'b0;
                    o_var_wr_en    = 1'b0;
                    o_var_wr_addr  = {VAR_W{1'b0}};
                    o_var_wr_state = 2'b00;
                end
            end
            ST_FLIP: begin
                o_stack_push   = 1'b1;
                o_push_type    = 1'b0;
                o_push_val     = ~r_val;
                o_push_var     = r_var;
                o_var_wr_en    = 1'b1;
                o_var_wr_addr  = r_var;
                o_var_wr_state = {1'b1, ~r_val};
            end
            default: begin
                o_stack_pop  = 1'b0;
                o_stack_push = 1'b0;
                o_var_wr_en  = 1'b0;
            end
        endcase
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_unsat     = r_unsat;
    assign o_pop_count = r_pop_count;

endmodule

// File: tb/tb_backtrack_unit.sv
// Self-checking bench for backtrack_unit with a behavioural trail-stack model.
module tb_backtrack_unit;

    typedef struct packed {
        logic       t;
        logic       v;
        logic [8:0] vr;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       o_busy, o_done, o_unsat;
    logic [8:0] o_pop_count;
    logic       stack_empty, stack_type, stack_val;
    logic [8:0] stack_var;
    logic       o_stack_pop, o_stack_push, o_push_type, o_push_val;
    logic [8:0] o_push_var;
    logic       o_var_wr_en;
    logic [8:0] o_var_wr_addr;
    logic [1:0] o_var_wr_state;
    logic [36:0] all_outs;

    int     n_checks = 0;
    int     n_fail   = 0;
    entry_t trail[$];
    logic   cap_pop, cap_push;
    entry_t cap_e;
    string  obs_trace;
    logic   obs_u1;

    backtrack_unit #(.NUM_VARIABLE(128), .VAR_W(9)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(o_busy), .o_done(o_done), .o_unsat(o_unsat), .o_pop_count(o_pop_count),
        .i_stack_empty(stack_empty), .i_stack_type(stack_type),
        .i_stack_val(stack_val), .i_stack_var(stack_var),
        .o_stack_pop(o_stack_pop), .o_stack_push(o_stack_push),
        .o_push_type(o_push_type), .o_push_val(o_push_val), .o_push_var(o_push_var),
        .o_var_wr_en(o_var_wr_en), .o_var_wr_addr(o_var_wr_addr),
        .o_var_wr_state(o_var_wr_state)
    );

    assign all_outs = {o_busy, o_done, o_unsat, o_pop_count, o_stack_pop, o_stack_push,
                       o_push_type, o_push_val, o_push_var, o_var_wr_en, o_var_wr_addr,
                       o_var_wr_state};

    always #5 clk = ~clk;

    function automatic entry_t mk(input logic t, input logic v, input int vr);
        entry_t e;
        e.t  = t;
        e.v  = v;
        e.vr = vr[8:0];
        return e;
    endfunction

    task automatic refresh();
        if (trail.size() == 0) begin
            stack_empty = 1'b1;
            stack_type  = 1'($urandom);
            stack_val   = 1'($urandom);
            stack_var   = 9'($urandom_range(0, 511));
        end else begin
            stack_empty = 1'b0;
            stack_type  = trail[$].t;
            stack_val   = trail[$].v;
            stack_var   = trail[$].vr;
        end
    endtask

    task automatic load(input entry_t tr[$]);
        trail = tr;
        refresh();
    endtask

    // Trail stack: strobes sampled mid-cycle, applied at the edge if not in reset
    always @(negedge clk) begin
        cap_pop  = o_stack_pop;
        cap_push = o_stack_push;
        cap_e    = mk(o_push_type, o_push_val, int'(o_push_var));
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (cap_pop && trail.size() > 0) trail.pop_back();
            if (cap_push) trail.push_back(cap_e);
        end
        #1 refresh();
    end

    function automatic string trail_str(input entry_t tr[$]);
        string s = "";
        foreach (tr[i]) s = {s, $sformatf("%0d%0d.%0d,", tr[i].t, tr[i].v, tr[i].vr)};
        return s;
    endfunction

    // Reference: pops run from the top down to and including the newest decision
    function automatic int model_pops(input entry_t tr[$]);
        int p = 0;
        for (int i = tr.size() - 1; i >= 0; i--) begin
            p++;
            if (tr[i].t) break;
        end
        return p;
    endfunction

    function automatic bit model_found(input entry_t tr[$]);
        foreach (tr[i]) if (tr[i].t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic string model_trace(input entry_t tr[$], input int ncyc);
        int     p = model_pops(tr);
        bit     f = model_found(tr);
        int     n = (p > 511) ? 511 : p;
        entry_t d = '0;
        string  s = "";
        if (f) d = tr[tr.size() - p];
        for (int c = 1; c <= ncyc; c++) begin
            s = {s, $sformatf("%0d:b%0d", c, (c <= p + 2) ? 1 : 0)};
            if (c <= p) s = {s, $sformatf(" P W%0d=0", tr[tr.size() - c].vr)};
            if (f && c == p + 1)
                s = {s, $sformatf(" H0%0d.%0d W%0d=%0d", d.v ? 0 : 1, d.vr, d.vr, d.v ? 2 : 3)};
            if (c == p + 2) s = {s, $sformatf(" D u%0d n%0d", f ? 0 : 1, n)};
            s = {s, ";"};
        end
        return s;
    endfunction

    function automatic string model_final(input entry_t tr[$]);
        entry_t q[$] = tr;
        int     p = model_pops(tr);
        bit     f = model_found(tr);
        entry_t d = '0;
        if (f) d = tr[tr.size() - p];
        repeat (p) q.pop_back();
        if (f) q.push_back(mk(1'b0, ~d.v, int'(d.vr)));
        return trail_str(q);
    endfunction

    // Accepts start at edge 0 and records one trace token per cycle 1..ncyc
    task automatic run_bt(input int ncyc, input bit hold);
        string s;
        obs_trace = "";
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) obs_u1 = o_unsat;
            s = $sformatf("%0d:b%0d", c, o_busy);
            if (o_stack_pop) s = {s, " P"};
            if (o_stack_push) s = {s, $sformatf(" H%0d%0d.%0d", o_push_type, o_push_val, o_push_var)};
            if (o_var_wr_en) s = {s, $sformatf(" W%0d=%0d", o_var_wr_addr, o_var_wr_state)};
            if (o_done) s = {s, $sformatf(" D u%0d n%0d", o_unsat, o_pop_count)};
            obs_trace = {obs_trace, s, ";"};
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (all_outs !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_outs !== 37'd0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h expected 0", all_outs);
        end
    endtask

    task automatic test_decision();
        entry_t tr[$];
        string  exp_t, exp_f;
        tr.push_back(mk(1'b1, 1'b1, 5));
        tr.push_back(mk(1'b0, 1'b0, 7));
        tr.push_back(mk(1'b0, 1'b1, 9));
        exp_t = "1:b1 P W9=0;2:b1 P W7=0;3:b1 P W5=0;4:b1 H00.5 W5=2;5:b1 D u0 n3;6:b0;7:b0;";
        exp_f = "00.5,";
        load(tr);
        run_bt(7, 1'b0);
        n_checks++;
        if (obs_trace != exp_t) begin
            n_fail++;
            $display("FAIL decision_trace: got %s expected %s", obs_trace, exp_t);
        end
        n_checks++;
        if (trail_str(trail) != exp_f) begin
            n_fail++;
            $display("FAIL decision_trail: got %s expected %s", trail_str(trail), exp_f);
        end
        n_checks++;
        if (o_pop_count !== 9'd3 || o_unsat !== 1'b0) begin
            n_fail++;
            $display("FAIL decision_status: got n=%0d u=%0d expected n=3 u=0", o_pop_count, o_unsat);
        end
    endtask

    task automatic test_empty();
        entry_t tr[$];
        string  exp_t = "1:b1;2:b1 D u1 n0;3:b0;4:b0;";
        load(tr);
        run_bt(4, 1'b0);
        n_checks++;
        if (obs_trace != exp_t) begin
            n_fail++;
            $display("FAIL empty_trace: got %s expected %s", obs_trace, exp_t);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_unsat !== 1'b1 || o_pop_count !== 9'd0) begin
            n_fail++;
            $display("FAIL unsat_sticky: got u=%0d n=%0d expected u=1 n=0", o_unsat, o_pop_count);
        end
    endtask

    task automatic test_imm_decision();
        entry_t tr[$];
        string  exp_t = "1:b1 P W12=0;2:b1 H01.12 W12=3;3:b1 D u0 n1;4:b0;5:b0;";
        tr.push_back(mk(1'b1, 1'b0, 12));
        load(tr);
        run_bt(5, 1'b0);
        n_checks++;
        if (obs_u1 !== 1'b0) begin
            n_fail++;
            $display("FAIL unsat_clear_on_start: got %0d expected 0", obs_u1);
        end
        n_checks++;
        if (obs_trace != exp_t) begin
            n_fail++;
            $display("FAIL imm_trace: got %s expected %s", obs_trace, exp_t);
        end
        n_checks++;
        if (trail_str(trail) != "01.12,") begin
            n_fail++;
            $display("FAIL imm_trail: got %s expected 01.12,", trail_str(trail));
        end
    endtask

    task automatic test_implied_only();
        entry_t tr[$];
        string  exp_t = "1:b1 P W4=0;2:b1 P W3=0;3:b1;4:b1 D u1 n2;5:b0;6:b0;";
        tr.push_back(mk(1'b0, 1'b1, 3));
        tr.push_back(mk(1'b0, 1'b0, 4));
        load(tr);
        run_bt(6, 1'b0);
        n_checks++;
        if (obs_trace != exp_t) begin
            n_fail++;
            $display("FAIL implied_trace: got %s expected %s", obs_trace, exp_t);
        end
        n_checks++;
        if (trail.size() != 0) begin
            n_fail++;
            $display("FAIL implied_trail: got %0d entries expected 0", trail.size());
        end
    endtask

    task automatic test_reset_mid();
        entry_t tr[$];
        entry_t rest[$];
        int     p;
        string  exp_t;
        tr.push_back(mk(1'b0, 1'b0, 2));
        tr.push_back(mk(1'b1, 1'b1, 20));
        for (int i = 21; i <= 25; i++) tr.push_back(mk(1'b0, 1'(i), i));
        load(tr);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h expected 0", all_outs);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (trail.size() != 5 || all_outs !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got %0d entries outs %h expected 5 entries outs 0",
                     trail.size(), all_outs);
        end
        rst_n = 1'b1;
        rest = trail;
        p = model_pops(rest);
        exp_t = model_trace(rest, p + 4);
        run_bt(p + 4, 1'b0);
        n_checks++;
        if (obs_trace != exp_t) begin
            n_fail++;
            $display("FAIL reset_mid_retry: got %s expected %s", obs_trace, exp_t);
        end
        n_checks++;
        if (trail_str(trail) != model_final(rest)) begin
            n_fail++;
            $display("FAIL reset_mid_trail: got %s expected %s", trail_str(trail), model_final(rest));
        end
    endtask

    task automatic test_start_hold();
        entry_t tr[$];
        string  exp_t;
        bit     seen = 1'b0;
        tr.push_back(mk(1'b1, 1'b1, 5));
        tr.push_back(mk(1'b0, 1'b0, 7));
        tr.push_back(mk(1'b0, 1'b1, 9));
        load(tr);
        exp_t = model_trace(tr, 6);
        run_bt(6, 1'b1);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (obs_trace != exp_t) begin
            n_fail++;
            $display("FAIL hold_trace: got %s expected %s", obs_trace, exp_t);
        end
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_restart: got busy=%0d expected 1", o_busy);
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL hold_second_done: got no done within 40 cycles expected done");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        entry_t tr[$];
        int     p;
        string  exp_t;
        for (int it = 0; it < 8; it++) begin
            tr.delete();
            for (int k = $urandom_range(0, 6); k > 0; k--)
                tr.push_back(mk(1'($urandom_range(0, 3) == 0), 1'($urandom), $urandom_range(0, 127)));
            p = model_pops(tr);
            exp_t = model_trace(tr, p + 4);
            load(tr);
            run_bt(p + 4, 1'b0);
            n_checks++;
            if (obs_trace != exp_t) begin
                n_fail++;
                $display("FAIL random_trace[%0d]: got %s expected %s", it, obs_trace, exp_t);
            end
            n_checks++;
            if (trail_str(trail) != model_final(tr)) begin
                n_fail++;
                $display("FAIL random_trail[%0d]: got %s expected %s", it, trail_str(trail), model_final(tr));
            end
        end
    endtask

    task automatic test_saturation();
        entry_t tr[$];
        for (int i = 0; i < 520; i++) tr.push_back(mk(1'b0, 1'($urandom), $urandom_range(0, 127)));
        load(tr);
        run_bt(523, 1'b0);
        n_checks++;
        if (o_pop_count !== 9'd511 || o_unsat !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation: got n=%0d u=%0d b=%0d expected n=511 u=1 b=0",
                     o_pop_count, o_unsat, o_busy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cap_pop = 1'b0;
        cap_push = 1'b0;
        refresh();
        test_reset();
        test_decision();
        test_empty();
        test_imm_decision();
        test_implied_only();
        test_reset_mid();
        test_start_hold();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
